exe_bypass: RTL and testbench
=============================

EXE_BYPASS -- requirements
Module: exe_bypass

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 Parameter FWD_DEPTH, default 2, range 1-4: retired-result history entries searched for register forwarding.
REQ-003 Parameter SB_DEPTH, default 4, power of two >= 2: store-buffer entries.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk, in, 1, sole clock.
- rst, in, 1, reset; asynchronous, active-low.
- rs1 / rs2, in, 5, source register indices.
- data1 / data2, in, XLEN, register-file read values.
- fwd_data1 / fwd_data2, out, XLEN, forwarded operands.
- wb_valid / wb_rd / wb_data, in, 1 / 5 / XLEN, result retiring this cycle.
- st_valid / st_addr / st_data, in, 1 / XLEN / XLEN, word store request.
- st_ready, out, 1, store accepted.
- ld_valid / ld_addr, in, 1 / XLEN, load lookup.
- ld_hit / ld_data, out, 1 / XLEN, store-to-load forward result.
- mem_wvalid / mem_waddr / mem_wdata, out, 1 / XLEN / XLEN, d-cache write request.
- mem_wready, in, 1, d-cache write accepted.
- sb_count, out, $clog2(SB_DEPTH)+1, store-buffer occupancy.

Function
REQ-005 History: a shift register of FWD_DEPTH {valid, rd, data} entries. When wb_valid=1 and wb_rd!=0, it pushes {1, wb_rd, wb_data} at the posedge. Otherwise it pushes an invalid entry. The oldest entry drops out.
REQ-006 fwd_data1 is combinational. It equals data from the youngest valid history entry whose rd==rs1; with no match it equals data1. fwd_data2 is the same using rs2.
REQ-007 rs==0 never forwards. In that case fwd_data equals data1 or data2 unmodified.
REQ-008 The same-cycle wb_* input is not a forwarding source; it becomes visible one cycle later.
REQ-009 The store buffer is a circular FIFO with SB_DEPTH entries {addr, data}.
- st_ready equals (sb_count < SB_DEPTH).
- An enqueue occurs on st_valid && st_ready.
- There is no enqueue when full, even if a drain happens in the same cycle.
REQ-010 Drain:
- mem_wvalid equals (sb_count != 0).
- mem_waddr and mem_wdata present the head entry.
- The head pops on mem_wvalid && mem_wready.
- mem_* stay stable while mem_wvalid=1 and mem_wready=0.
REQ-011 An enqueue and a pop in the same cycle leave sb_count unchanged. Head and tail pointers wrap modulo SB_DEPTH.
REQ-012 Load lookup compares ld_addr[XLEN-1:2] against every occupied entry and against the same-cycle accepted store.
- The same-cycle accepted store counts as the youngest entry.
- The youngest match wins.
- ld_hit = ld_valid && match.
- ld_data is the matched data, else 0.
- Latency is 0 cycles, fully combinational.
REQ-013 The entry popping in the current cycle still participates in the lookup during that cycle.
REQ-014 Addresses are word-granular; bits [1:0] are ignored in both store and lookup.

Reset
REQ-015 While rst=0, all of the following hold, independent of clk:
- History entries are invalid.
- Pointers are 0 and sb_count=0.
- mem_wvalid=0, st_ready=1, ld_hit=0.
REQ-016 Reset during an outstanding drain discards all buffered stores. mem_wvalid drops immediately.

Configuration
REQ-017 Macro EXE_SB_FWD_EN.
- Defined: REQ-012 and REQ-013 apply.
- Undefined: ld_hit=0 and ld_data=0 always, and no comparators are built. The FIFO and drain are unchanged.

Structure
REQ-018 Package exe_pkg holds XLEN, the history entry struct, the store-buffer entry struct and the register index width.
REQ-019 The FIFO and load lookup are implemented in sub-module exe_store_buf. History and operand muxing stay in exe_bypass.

Verification
REQ-020 Register forwarding:
- Stimulus: wb x5=0x11 at cycle n, then x5=0x22 at n+1; rs1=5 at n+2.
- Response: fwd_data1=0x22 (youngest wins).
REQ-021 Register zero:
- Stimulus: wb x0=0xFF; then rs1=0 with data1=0.
- Response: fwd_data1=0.
REQ-022 Full buffer (SB_DEPTH=4):
- Stimulus: 4 stores with mem_wready=0.
- Response: st_ready=0 and sb_count=4.
- Stimulus: a fifth st_valid is held while mem_wready=1 for one cycle.
- Response: sb_count=3. The fifth store is accepted on the following cycle.
REQ-023 Store-to-load forwarding:
- Stimulus: stores 0x100<-0xA, then 0x100<-0xB; ld_addr=0x102.
- Response: ld_hit=1, ld_data=0xB.
- Stimulus: ld_addr=0x104.
- Response: ld_hit=0.
REQ-024 Same-cycle store and drain pop:
- Stimulus: st 0x200<-0xC in the same cycle as ld 0x200.
- Response: ld_hit=1, ld_data=0xC.
- Stimulus: the head pops while it is being looked up.
- Response: still a hit.
REQ-025 Reset mid-operation:
- Stimulus: rst low with 3 entries buffered and mem_wready=0.
- Response: mem_wvalid=0 and sb_count=0 immediately; after release st_ready=1.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared types for the execute-stage bypass: operand history entries and store-buffer entries.
package exe_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } hist_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/exe_store_buf.sv
// Circular store buffer with d-cache drain and combinational store-to-load lookup.
// The lookup comparators exist only when EXE_SB_FWD_EN is defined.
module exe_store_buf
  import exe_pkg::*;
#(
  parameter  int unsigned SB_DEPTH = 4,
  localparam int unsigned PTR_W    = $clog2(SB_DEPTH),
  localparam int unsigned CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid_i,
  input  logic [XLEN-1:0]  st_addr_i,
  input  logic [XLEN-1:0]  st_data_i,
  output logic             st_ready_o,
  input  logic             ld_valid_i,
  input  logic [XLEN-1:0]  ld_addr_i,
  output logic             ld_hit_o,
  output logic [XLEN-1:0]  ld_data_o,
  output logic             mem_wvalid_o,
  output logic [XLEN-1:0]  mem_waddr_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  input  logic             mem_wready_i,
  output logic [CNT_W-1:0] sb_count_o
);

  sb_entry_t        sb_q [SB_DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_c;
  logic             pop_c;

  assign st_ready_o   = (count_q < CNT_W'(SB_DEPTH));
  assign push_c       = st_valid_i && st_ready_o;
  assign mem_wvalid_o = (count_q != '0);
  assign pop_c        = mem_wvalid_o && mem_wready_i;
  assign mem_waddr_o  = sb_q[head_q].addr;
  assign mem_wdata_o  = sb_q[head_q].data;
  assign sb_count_o   = count_q;

  // Simultaneous push and pop leave occupancy unchanged.
  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      if (push_c) begin
        sb_q[tail_q] <= '{addr: st_addr_i, data: st_data_i};
        tail_q       <= tail_q + PTR_W'(1);
      end
      if (pop_c) begin
        head_q <= head_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

`ifdef EXE_SB_FWD_EN
  logic             match_c;
  logic [XLEN-1:0]  match_data_c;
  logic [PTR_W-1:0] idx_c;
  logic             ld_lsb_unused;

  // Scan oldest to youngest so later matches override; the accepted store is youngest of all.
  always_comb begin
    match_c      = 1'b0;
    match_data_c = '0;
    idx_c        = head_q;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      idx_c = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (sb_q[idx_c].addr[XLEN-1:2] == ld_addr_i[XLEN-1:2])) begin
        match_c      = 1'b1;
        match_data_c = sb_q[idx_c].data;
      end
    end
    if (push_c && (st_addr_i[XLEN-1:2] == ld_addr_i[XLEN-1:2])) begin
      match_c      = 1'b1;
      match_data_c = st_data_i;
    end
  end

  assign ld_hit_o      = rst_n && ld_valid_i && match_c;
  assign ld_data_o     = rst_n ? match_data_c : '0;
  assign ld_lsb_unused = ^ld_addr_i[1:0];
`else
  logic ld_unused;

  assign ld_hit_o  = 1'b0;
  assign ld_data_o = '0;
  assign ld_unused = ^{ld_valid_i, ld_addr_i};
`endif

endmodule

// File: rtl/exe_bypass.sv
// Execute-stage bypass: register operand forwarding from retired-result history plus store buffer.
// Optional store-to-load forwarding is enabled by defining EXE_SB_FWD_EN.
module exe_bypass
  import exe_pkg::*;
#(
  parameter int unsigned XLEN      = exe_pkg::XLEN,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned SB_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_W-1:0]          rs1,
  input  logic [REG_W-1:0]          rs2,
  input  logic [XLEN-1:0]           data1,
  input  logic [XLEN-1:0]           data2,
  output logic [XLEN-1:0]           fwd_data1,
  output logic [XLEN-1:0]           fwd_data2,
  input  logic                      wb_valid,
  input  logic [REG_W-1:0]          wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      st_valid,
  input  logic [XLEN-1:0]           st_addr,
  input  logic [XLEN-1:0]           st_data,
  output logic                      st_ready,
  input  logic                      ld_valid,
  input  logic [XLEN-1:0]           ld_addr,
  output logic                      ld_hit,
  output logic [XLEN-1:0]           ld_data,
  output logic                      mem_wvalid,
  output logic [XLEN-1:0]           mem_waddr,
  output logic [XLEN-1:0]           mem_wdata,
  input  logic                      mem_wready,
  output logic [$clog2(SB_DEPTH):0] sb_count
);

  // Index 0 is the youngest retired result.
  hist_entry_t hist_q [FWD_DEPTH];
  hist_entry_t hist_d [FWD_DEPTH];

  always_comb begin
    hist_d[0] = '{valid: wb_valid && (wb_rd != '0), rd: wb_rd, data: wb_data};
    for (int unsigned i = 1; i < FWD_DEPTH; i++) begin
      hist_d[i] = hist_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins; x0 never forwards.
  always_comb begin
    fwd_data1 = data1;
    fwd_data2 = data2;
    for (int i = int'(FWD_DEPTH) - 1; i >= 0; i--) begin
      if (hist_q[i].valid && (rs1 != '0) && (hist_q[i].rd == rs1)) begin
        fwd_data1 = hist_q[i].data;
      end
      if (hist_q[i].valid && (rs2 != '0) && (hist_q[i].rd == rs2)) begin
        fwd_data2 = hist_q[i].data;
      end
    end
  end

  exe_store_buf #(
    .SB_DEPTH (SB_DEPTH)
  ) u_store_buf (
    .clk          (clk),
    .rst_n        (rst),
    .st_valid_i   (st_valid),
    .st_addr_i    (st_addr),
    .st_data_i    (st_data),
    .st_ready_o   (st_ready),
    .ld_valid_i   (ld_valid),
    .ld_addr_i    (ld_addr),
    .ld_hit_o     (ld_hit),
    .ld_data_o    (ld_data),
    .mem_wvalid_o (mem_wvalid),
    .mem_waddr_o  (mem_waddr),
    .mem_wdata_o  (mem_wdata),
    .mem_wready_i (mem_wready),
    .sb_count_o   (sb_count)
  );

endmodule

// File: tb/tb_exe_bypass.sv
// Randomized self-checking bench for exe_bypass against a queue-based reference model.
module tb_exe_bypass;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned FWD_DEPTH = 2;
  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned CNT_W     = $clog2(SB_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1, rs2, wb_rd;
  logic [XLEN-1:0]  data1, data2, wb_data, st_addr, st_data, ld_addr;
  logic             wb_valid, st_valid, ld_valid, mem_wready;
  logic [XLEN-1:0]  fwd_data1, fwd_data2, ld_data, mem_waddr, mem_wdata;
  logic             st_ready, ld_hit, mem_wvalid;
  logic [CNT_W-1:0] sb_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  exe_bypass #(
    .XLEN      (XLEN),
    .FWD_DEPTH (FWD_DEPTH),
    .SB_DEPTH  (SB_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1        (rs1),
    .rs2        (rs2),
    .data1      (data1),
    .data2      (data2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_ready   (st_ready),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .ld_data    (ld_data),
    .mem_wvalid (mem_wvalid),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wready (mem_wready),
    .sb_count   (sb_count)
  );

  // Reference model: recent retirements (front = youngest, rd 0 = no result) and pending stores.
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } hist_t;
  typedef struct {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } st_t;

  hist_t hist_m[$];
  st_t   sb_m[$];

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [XLEN-1:0] exp_fwd(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 5'd0) return rf;
    for (int i = 0; i < hist_m.size(); i++) begin
      if (hist_m[i].rd == rs) return hist_m[i].data;
    end
    return rf;
  endfunction

  function automatic bool_room();
    return sb_m.size() < int'(SB_DEPTH);
  endfunction

  task automatic exp_load(output logic hit, output logic [XLEN-1:0] data);
    logic found;
    found = 1'b0;
    data  = '0;
`ifdef EXE_SB_FWD_EN
    for (int i = 0; i < sb_m.size(); i++) begin
      if ((sb_m[i].addr >> 2) == (ld_addr >> 2)) begin
        found = 1'b1;
        data  = sb_m[i].data;
      end
    end
    if (st_valid && bool_room() && ((st_addr >> 2) == (ld_addr >> 2))) begin
      found = 1'b1;
      data  = st_data;
    end
`endif
    hit = ld_valid && found;
  endtask

  task automatic model_reset();
    hist_m.delete();
    sb_m.delete();
  endtask

  task automatic model_clock();
    hist_t h;
    bit    push, pop;
    push   = st_valid && bool_room();
    pop    = (sb_m.size() != 0) && mem_wready;
    h.rd   = (wb_valid && wb_rd != 5'd0) ? wb_rd : 5'd0;
    h.data = wb_data;
    hist_m.push_front(h);
    if (hist_m.size() > int'(FWD_DEPTH)) void'(hist_m.pop_back());
    if (pop) void'(sb_m.pop_front());
    if (push) sb_m.push_back('{addr: st_addr, data: st_data});
  endtask

  task automatic check_all();
    logic            e_hit;
    logic [XLEN-1:0] e_data;
    exp_load(e_hit, e_data);
    check_eq("fwd1", fwd_data1, exp_fwd(rs1, data1));
    check_eq("fwd2", fwd_data2, exp_fwd(rs2, data2));
    check_eq("st_ready", 32'(st_ready), 32'(bool_room()));
    check_eq("sb_count", 32'(sb_count), 32'(sb_m.size()));
    check_eq("mem_wvalid", 32'(mem_wvalid), 32'(sb_m.size() != 0));
    if (sb_m.size() != 0) begin
      check_eq("mem_waddr", mem_waddr, sb_m[0].addr);
      check_eq("mem_wdata", mem_wdata, sb_m[0].data);
    end
    check_eq("ld_hit", 32'(ld_hit), 32'(e_hit));
    check_eq("ld_data", ld_data, e_data);
  endtask

  // Check mid-cycle, then advance one clock and mirror it in the model.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    if (rst) model_clock();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    {wb_valid, st_valid, ld_valid, mem_wready} = '0;
    {rs1, rs2, wb_rd} = '0;
    {data1, data2, wb_data, st_addr, st_data, ld_addr} = '0;
    model_reset();
    #2;
    check_eq("rst_mem_wvalid", 32'(mem_wvalid), 32'd0);
    check_eq("rst_sb_count", 32'(sb_count), 32'd0);
    check_eq("rst_st_ready", 32'(st_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Youngest of two writes to the same register wins.
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h11;
    step();
    wb_data = 32'h22;
    step();
    wb_valid = 1'b0; rs1 = 5'd5; data1 = 32'h99; rs2 = 5'd5; data2 = 32'h77;
    #1 check_eq("req020_fwd1", fwd_data1, 32'h22);
    check_eq("req020_fwd2", fwd_data2, 32'h22);
    step();

    // A same-cycle writeback is not yet visible.
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h33; rs1 = 5'd6; data1 = 32'h44;
    #1 check_eq("samecyc_wb", fwd_data1, 32'h44);
    step();
    wb_valid = 1'b0;
    #1 check_eq("nextcyc_wb", fwd_data1, 32'h33);
    step();

    // x0 never forwards.
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
    step();
    wb_valid = 1'b0; rs1 = 5'd0; data1 = 32'h0;
    #1 check_eq("req021_x0", fwd_data1, 32'h0);
    step();

    // Fill the buffer with the drain stalled, then free one slot.
    mem_wready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      st_valid = 1'b1; st_addr = 32'h300 + 32'(4 * k); st_data = 32'(k + 1);
      step();
    end
    st_valid = 1'b0;
    #1 check_eq("full_st_ready", 32'(st_ready), 32'd0);
    check_eq("full_sb_count", 32'(sb_count), 32'd4);
    step();
    st_valid = 1'b1; st_addr = 32'h310; st_data = 32'h5; mem_wready = 1'b1;
    #1 check_eq("full_no_enq", 32'(st_ready), 32'd0);
    step();
    mem_wready = 1'b0;
    #1 check_eq("after_pop_count", 32'(sb_count), 32'd3);
    check_eq("after_pop_ready", 32'(st_ready), 32'd1);
    step();
    st_valid = 1'b0;
    #1 check_eq("fifth_accepted", 32'(sb_count), 32'd4);
    check_eq("head_after_pop", mem_waddr, 32'h304);
    mem_wready = 1'b1;
    repeat (4) step();
    mem_wready = 1'b0;
    #1 check_eq("drained", 32'(sb_count), 32'd0);

    // Store-to-load forwarding, including same-cycle store and popping head.
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hA;
    step();
    st_data = 32'hB;
    step();
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h102;
`ifdef EXE_SB_FWD_EN
    #1 check_eq("req023_hit", 32'(ld_hit), 32'd1);
    check_eq("req023_data", ld_data, 32'hB);
`endif
    step();
    ld_addr = 32'h104;
    #1 check_eq("req023_miss", 32'(ld_hit), 32'd0);
    step();
    st_valid = 1'b1; st_addr = 32'h200; st_data = 32'hC; ld_addr = 32'h200;
`ifdef EXE_SB_FWD_EN
    #1 check_eq("req024_same_hit", 32'(ld_hit), 32'd1);
    check_eq("req024_same_data", ld_data, 32'hC);
`endif
    step();
    st_valid = 1'b0; ld_valid = 1'b0; mem_wready = 1'b1;
    step();
    step();
    ld_valid = 1'b1;
`ifdef EXE_SB_FWD_EN
    #1 check_eq("req024_pop_hit", 32'(ld_hit), 32'd1);
    check_eq("req024_pop_data", ld_data, 32'hC);
`endif
    step();
    mem_wready = 1'b0; ld_valid = 1'b0;
    #1 check_eq("empty_again", 32'(sb_count), 32'd0);

    // Reset with stores buffered and a result in history.
    for (int k = 0; k < 3; k++) begin
      st_valid = 1'b1; st_addr = 32'h400 + 32'(4 * k); st_data = 32'(16 + k);
      step();
    end
    st_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hABC;
    step();
    wb_valid = 1'b0;
    #1 rst = 1'b0;
    st_valid = 1'b1; st_addr = 32'h400; ld_valid = 1'b1; ld_addr = 32'h400;
    #1 check_eq("req025_wvalid", 32'(mem_wvalid), 32'd0);
    check_eq("req025_count", 32'(sb_count), 32'd0);
    check_eq("req025_ready", 32'(st_ready), 32'd1);
    check_eq("req025_ld_hit", 32'(ld_hit), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    st_valid = 1'b0; ld_valid = 1'b0; rs1 = 5'd9; data1 = 32'h55;
    #1 check_eq("req025_post_ready", 32'(st_ready), 32'd1);
    check_eq("req025_hist_clear", fwd_data1, 32'h55);
    step();

    // Randomized traffic with small register and address spaces to force collisions.
    for (int n = 0; n < 800; n++) begin
      wb_valid   = 1'($urandom_range(0, 1));
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      rs1        = 5'($urandom_range(0, 7));
      rs2        = 5'($urandom_range(0, 7));
      data1      = $urandom;
      data2      = $urandom;
      st_valid   = ($urandom_range(0, 2) != 0);
      st_addr    = 32'h100 + 32'($urandom_range(0, 31));
      st_data    = $urandom;
      mem_wready = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      ld_valid   = 1'($urandom_range(0, 1));
      ld_addr    = 32'h100 + 32'($urandom_range(0, 31));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
